// File: rtl/ik_swift_pkg.sv
// ik_swift_pkg: shared FSM states, default sizes and word type for the IK iteration controller
package ik_swift_pkg;
  localparam int NJ_D = 6;
  localparam int W_D = 36;
  localparam int IW_D = 8;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_EVAL, S_FIN} state_t;
  typedef logic signed [W_D-1:0] word_t;
endpackage

// File: rtl/ik_swift_delta_chk.sv
// ik_swift_delta_chk: saturating |delta| <= tol check across all joints
module ik_swift_delta_chk #(
  parameter int NJ = 6,
  parameter int W = 36
) (
  input  logic [NJ*W-1:0] delta,
  input  logic [W-1:0]    tol,
  output logic            within_tol
);
  logic [NJ-1:0] ok;
  for (genvar j = 0; j < NJ; j++) begin : g_j
    logic [W-1:0] x, a;
    assign x = delta[j*W +: W];
    // most-negative value has no positive twin, so clamp it to the largest positive
    assign a = !x[W-1] ? x : (x[W-2:0] == '0 ? {1'b0, {(W-1){1'b1}}} : -x);
    assign ok[j] = a <= tol;
  end
  assign within_tol = &ok;
endmodule

// File: rtl/ik_swift_iter_ctrl.sv
// ik_swift_iter_ctrl: IK iteration sequencer; define IK_SWIFT_WATCHDOG_EN for a per-iteration watchdog
module ik_swift_iter_ctrl
  import ik_swift_pkg::*;
#(
  parameter int NJ = NJ_D,
  parameter int W = W_D,
  parameter int IW = IW_D
`ifdef IK_SWIFT_WATCHDOG_EN
  , parameter int WDOG_CYC = 4096
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NJ*W-1:0] dh_dyn_in,
  input  logic [W-1:0]    tolerance,
  input  logic [IW-1:0]   max_iter,
  output logic            busy,
  output logic            done,
  output logic            converged,
  output logic            timeout,
  output logic [IW-1:0]   iter_count,
  output logic [NJ*W-1:0] dh_dyn_out,
  output logic            core_rst,
  output logic            core_en,
  output logic [NJ*W-1:0] core_dh_dyn_in,
  input  logic            core_done,
  input  logic [NJ*W-1:0] core_delta,
  input  logic [NJ*W-1:0] core_dh_dyn_out
);
  state_t state_q, state_d;
  logic [NJ*W-1:0] work_q, work_d;
  logic [W-1:0] tol_q, tol_d;
  logic [IW-1:0] max_q, max_d, iter_q, iter_d;
  logic conv_q, conv_d, within_tol;
`ifdef IK_SWIFT_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_CYC) + 1;
  logic [WCW-1:0] wd_q, wd_d;
  logic tmo_q, tmo_d;
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif
  ik_swift_delta_chk #(.NJ(NJ), .W(W)) u_chk (
    .delta(core_delta), .tol(tol_q), .within_tol(within_tol)
  );
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    tol_d = tol_q;
    max_d = max_q;
    iter_d = iter_q;
    conv_d = conv_q;
`ifdef IK_SWIFT_WATCHDOG_EN
    wd_d = wd_q;
    tmo_d = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (en) begin
        work_d = dh_dyn_in;
        tol_d = tolerance;
        max_d = max_iter == '0 ? IW'(1) : max_iter;
        iter_d = '0;
        conv_d = 1'b0;
`ifdef IK_SWIFT_WATCHDOG_EN
        tmo_d = 1'b0;
`endif
        state_d = S_CLR;
      end
      S_CLR: begin
`ifdef IK_SWIFT_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: if (core_done) state_d = S_EVAL;
`ifdef IK_SWIFT_WATCHDOG_EN
      else if (wd_q == WCW'(WDOG_CYC - 1)) begin
        tmo_d = 1'b1;
        state_d = S_FIN;
      end else wd_d = wd_q + 1'b1;
`endif
      S_EVAL: begin
        work_d = core_dh_dyn_out;
        iter_d = iter_q + 1'b1;
        conv_d = within_tol;
        state_d = (within_tol || iter_d == max_q) ? S_FIN : S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q <= '0;
      tol_q <= '0;
      max_q <= '0;
      iter_q <= '0;
      conv_q <= 1'b0;
`ifdef IK_SWIFT_WATCHDOG_EN
      wd_q <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      tol_q <= tol_d;
      max_q <= max_d;
      iter_q <= iter_d;
      conv_q <= conv_d;
`ifdef IK_SWIFT_WATCHDOG_EN
      wd_q <= wd_d;
      tmo_q <= tmo_d;
`endif
    end
  end
  assign busy = state_q inside {S_CLR, S_RUN, S_EVAL};
  assign done = state_q == S_FIN;
  assign converged = conv_q;
  assign iter_count = iter_q;
  assign dh_dyn_out = work_q;
  assign core_rst = rst || state_q == S_CLR;
  assign core_en = state_q == S_RUN;
  assign core_dh_dyn_in = work_q;
endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
// tb_ik_swift_iter_ctrl: directed and random runs against a behavioural IK-core and result model
module tb_ik_swift_iter_ctrl;
  import ik_swift_pkg::*;
  localparam int NJ = NJ_D, W = W_D, IW = IW_D, V = NJ * W;
  logic clk = 0, rst = 1, en = 0;
  logic [V-1:0] dh_dyn_in = '0;
  logic [W-1:0] tolerance = '0;
  logic [IW-1:0] max_iter = '0;
  logic busy, done, converged, timeout, core_rst, core_en, core_done;
  logic [IW-1:0] iter_count;
  logic [V-1:0] dh_dyn_out, core_dh_dyn_in, core_delta, core_dh_dyn_out;
  logic [W-1:0] dv [NJ];
  int total = 0, bad = 0, lat = 5, ccnt = 0;
  bit never = 0;

`ifdef IK_SWIFT_WATCHDOG_EN
  ik_swift_iter_ctrl #(.WDOG_CYC(16)) dut (
`else
  ik_swift_iter_ctrl dut (
`endif
    .clk(clk), .rst(rst), .en(en), .dh_dyn_in(dh_dyn_in), .tolerance(tolerance),
    .max_iter(max_iter), .busy(busy), .done(done), .converged(converged),
    .timeout(timeout), .iter_count(iter_count), .dh_dyn_out(dh_dyn_out),
    .core_rst(core_rst), .core_en(core_en), .core_dh_dyn_in(core_dh_dyn_in),
    .core_done(core_done), .core_delta(core_delta), .core_dh_dyn_out(core_dh_dyn_out)
  );

  always #5 clk = ~clk;

  // core model: done (level) after lat enabled cycles, each joint advanced by one
  always @(posedge clk) ccnt <= (core_en && !core_rst) ? ccnt + 1 : 0;
  assign core_done = core_en && !never && ccnt >= lat;
  always_comb begin
    core_delta = '0;
    core_dh_dyn_out = '0;
    for (int j = 0; j < NJ; j++) begin
      core_delta[j*W +: W] = dv[j];
      core_dh_dyn_out[j*W +: W] = core_dh_dyn_in[j*W +: W] + W'(1);
    end
  end

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_conv(input logic [W-1:0] tol);
    longint lim = (longint'(1) <<< (W - 1)) - 1;
    for (int j = 0; j < NJ; j++) begin
      longint d = longint'(signed'(dv[j]));
      longint a = d < 0 ? -d : d;
      if (a > lim) a = lim;
      if (a > longint'(tol)) return 0;
    end
    return 1;
  endfunction

  task automatic set_dv(input logic [W-1:0] v);
    for (int j = 0; j < NJ; j++) dv[j] = v;
  endtask

  task automatic run(input logic [V-1:0] init, input logic [W-1:0] tol,
                     input logic [IW-1:0] mi, input bit exp_tmo, input string tag);
    int n_rst = 1, cyc = 0, iters;
    bit got = 0, cv;
    logic [V-1:0] exp_dh;
    cv = !exp_tmo && ref_conv(tol);
    iters = exp_tmo ? 0 : (cv ? 1 : (mi == 0 ? 1 : int'(mi)));
    for (int j = 0; j < NJ; j++) exp_dh[j*W +: W] = init[j*W +: W] + W'(iters);
    dh_dyn_in = init; tolerance = tol; max_iter = mi; en = 1;
    @(negedge clk);
    en = 0;
    chk({tag, ".clr_rst"}, V'(core_rst), V'(1));
    chk({tag, ".clr_en"}, V'(core_en), V'(0));
    chk({tag, ".clr_busy"}, V'(busy), V'(1));
    @(negedge clk);
    chk({tag, ".first_en"}, V'(core_en), V'(1));
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (core_rst) n_rst++;
      if (done) got = 1; else en = 1'($urandom_range(0, 1));
    end
    en = 0;
    chk({tag, ".done_seen"}, V'(got), V'(1));
    chk({tag, ".converged"}, V'(converged), V'(cv));
    chk({tag, ".timeout"}, V'(timeout), V'(exp_tmo));
    chk({tag, ".iter_count"}, V'(iter_count), V'(iters));
    chk({tag, ".dh_out"}, dh_dyn_out, exp_dh);
    chk({tag, ".rst_pulses"}, V'(n_rst), V'(exp_tmo ? 1 : iters));
    @(negedge clk);
    chk({tag, ".done_1cyc"}, V'(done), V'(0));
    chk({tag, ".idle_busy"}, V'(busy), V'(0));
    chk({tag, ".hold_iter"}, V'(iter_count), V'(iters));
  endtask

  initial begin
    logic [V-1:0] init;
    logic [W-1:0] tol;
    int cyc;
    set_dv('0);
    repeat (3) @(negedge clk);
    chk("rst.busy", V'(busy), V'(0));
    chk("rst.done", V'(done), V'(0));
    chk("rst.conv", V'(converged), V'(0));
    chk("rst.tmo", V'(timeout), V'(0));
    chk("rst.iter", V'(iter_count), V'(0));
    chk("rst.dh", dh_dyn_out, V'(0));
    chk("rst.core_en", V'(core_en), V'(0));
    chk("rst.core_rst", V'(core_rst), V'(1));
    rst = 0;
    @(negedge clk);
    chk("post_rst.core_rst", V'(core_rst), V'(0));
    lat = 5; set_dv('0);
    run({NJ{W'(36'h123)}}, W'(0), 8'd10, 0, "zero_delta");
    set_dv(W'(36'h100));
    run({NJ{W'(36'h7)}}, W'(36'h80), 8'd4, 0, "no_conv");
    set_dv(36'h800000000);
    run('0, 36'h7FFFFFFFF, 8'd3, 0, "maxneg_in");
    run('0, 36'h7FFFFFFFE, 8'd2, 0, "maxneg_out");
    set_dv(W'(36'h100)); lat = 2;
    run({NJ{W'(36'hFFFFFFFFF)}}, W'(36'h10), 8'd0, 0, "max0");
    for (int k = 0; k < 8; k++) begin
      lat = $urandom_range(0, 6);
      tol = W'($urandom_range(0, 'h200));
      for (int j = 0; j < NJ; j++) begin
        dv[j] = W'($urandom_range(0, 'h400)) - W'('h200);
        init[j*W +: W] = W'({$urandom, $urandom});
      end
      if (k == 3) dv[2] = 36'h800000000;
      run(init, tol, IW'($urandom_range(0, 5)), 0, $sformatf("rnd%0d", k));
    end
    set_dv(W'(36'h100)); lat = 3;
    dh_dyn_in = {NJ{W'(36'h55)}}; tolerance = W'(36'h80); max_iter = 8'd4; en = 1;
    @(negedge clk);
    en = 0;
    cyc = 0;
    while (!(iter_count == 8'd1 && core_en) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("mid.reached_run2", V'(cyc < 200), V'(1));
    rst = 1;
    @(negedge clk);
    chk("mid.busy", V'(busy), V'(0));
    chk("mid.core_en", V'(core_en), V'(0));
    chk("mid.core_rst", V'(core_rst), V'(1));
    chk("mid.iter", V'(iter_count), V'(0));
    chk("mid.dh", dh_dyn_out, V'(0));
    rst = 0;
    @(negedge clk);
    chk("mid.idle_busy", V'(busy), V'(0));
`ifdef IK_SWIFT_WATCHDOG_EN
    never = 1; set_dv('0);
    run({NJ{W'(36'hABC)}}, W'(36'h80), 8'd5, 1, "wdog");
    never = 0;
`endif
    lat = 1; set_dv('0);
    run({NJ{W'(36'h1)}}, W'(0), 8'd255, 0, "after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ik_swift_iter_ctrl.md
IK_SWIFT_ITER_CTRL -- requirements
Module: ik_swift_iter_ctrl

Interface
REQ-001 Parameter NJ, 6, joint count.
REQ-002 Parameter W, 36, signed fixed-point word width.
REQ-003 Parameter IW, 8, iteration-counter width.
REQ-004 Parameter WDOG_CYC, 4096, watchdog limit in cycles per iteration (only with the watchdog feature).
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  start request, sampled in IDLE.
REQ-008 dh_dyn_in  in  NJ*W  initial joint parameters.
REQ-009 tolerance  in  W  unsigned convergence threshold on |delta|.
REQ-010 max_iter  in  IW  iteration limit.
REQ-011 busy  out  1  run in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 converged  out  1  last run met tolerance.
REQ-014 timeout  out  1  last run aborted by watchdog.
REQ-015 iter_count  out  IW  iterations completed in the last run.
REQ-016 dh_dyn_out  out  NJ*W  current or final joint parameters.
REQ-017 core_rst  out  1  reset to the IK core.
REQ-018 core_en  out  1  enable to the IK core.
REQ-019 core_dh_dyn_in  out  NJ*W  joint parameters presented to the core.
REQ-020 core_done  in  1  core iteration complete, level.
REQ-021 core_delta  in  NJ*W  signed per-joint deltas from the core.
REQ-022 core_dh_dyn_out  in  NJ*W  updated joint parameters from the core.

Function
REQ-023 FSM states: IDLE, CLR, RUN, EVAL, FIN.
REQ-024 IDLE with en=1: latch dh_dyn_in into the working register, latch tolerance and max_iter (0 treated as 1), clear iter_count, converged and timeout, then go to CLR.
REQ-025 en is ignored in every state except IDLE.
REQ-026 CLR: core_rst=1 and core_en=0 for exactly one cycle, then go to RUN.
REQ-027 RUN: core_en=1 and core_dh_dyn_in = working register; stay until core_done=1, then go to EVAL.
REQ-028 EVAL (one cycle): working register <= core_dh_dyn_out; iter_count increments by 1.
REQ-029 EVAL sets converged=1 when |core_delta[j]| <= tolerance for every j.
REQ-030 |x| of the most-negative W-bit value saturates to 2^(W-1)-1.
REQ-031 EVAL exit: go to FIN when converged=1 or iter_count (after increment) = max_iter; otherwise go to CLR.
REQ-032 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-033 busy=1 in CLR, RUN and EVAL.
REQ-034 Between runs, outputs other than done hold their values.
REQ-035 dh_dyn_out always equals the working register.
REQ-036 Start-to-first-core_en latency is 2 cycles; each iteration costs 3 cycles plus core latency.
REQ-037 iter_count never wraps; max_iter caps it at 2^IW-1.

Reset
REQ-038 rst=1 at a clk edge forces IDLE from any state.
REQ-039 Reset values: busy=0, done=0, converged=0, timeout=0, iter_count=0, working register=0, core_en=0.
REQ-040 While rst=1, core_rst=1, so a mid-run reset also resets the core.

Configuration
REQ-041 With IK_SWIFT_WATCHDOG_EN defined: a counter clears on entering RUN and increments each RUN cycle.
REQ-042 Watchdog expiry: if the counter reaches WDOG_CYC-1 without core_done, set timeout=1, keep the working register, and go to FIN.
REQ-043 If core_done and expiry coincide, core_done wins.
REQ-044 Without IK_SWIFT_WATCHDOG_EN: no counter exists, timeout is tied 0, and RUN waits indefinitely.

Structure
REQ-045 Package ik_swift_pkg holds the FSM state enum, the default NJ/W/IW constants, and a word typedef logic signed [W-1:0].
REQ-046 One sub-module, ik_swift_delta_chk, holds the combinational abs-saturate-compare across NJ joints and outputs a single within_tol bit.

Verification
REQ-047 Core model: done after 5 cycles with all deltas 0; en=1, max_iter=10 -> converged=1, iter_count=1, done pulse 1 cycle after EVAL.
REQ-048 Deltas held at 0x100, tolerance 0x80, max_iter=4 -> converged=0, iter_count=4, exactly 4 core_rst pulses.
REQ-049 Delta = most-negative value (0x800000000), tolerance 0x7FFFFFFFF -> converged=1 on iteration 1.
REQ-050 rst asserted during RUN of iteration 2 -> next cycle IDLE, busy=0, core_en=0, core_rst=1, iter_count=0.
REQ-051 With IK_SWIFT_WATCHDOG_EN and WDOG_CYC=16, core never done -> timeout=1, done pulse, iter_count=0; en pulsed while busy is ignored.
REQ-052 max_iter=0 -> exactly one iteration runs, iter_count=1.
